bram_arbiter: RTL
=================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, BRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 10, maximum reads in flight (equal to controller latency).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cache_req / cache_wr  input  1 / 1  CPU cache request valid; write when 1, read when 0.
REQ-007 cache_addr / cache_wdata  input  ADDR_W / DATA_W  cache request address and write data.
REQ-008 cache_gnt  output  1  cache request accepted this cycle.
REQ-009 dma_req, dma_wr, dma_addr, dma_wdata, dma_gnt  same widths and meaning as the cache_* ports, for the DMA.
REQ-010 WR, In_valid, Addr, Di, reader_sel  output  1, 1, ADDR_W, DATA_W, 1  request to the BRAM controller; reader_sel is 0 for DMA and 1 for CPU.
REQ-011 bram_Do  input  DATA_W  controller read data.
REQ-012 bram_Out_valid, bram_dma_ack  input  1, 1  controller response strobes.
REQ-013 cache_rdata, cache_rvalid  output  DATA_W, 1  read return to the cache.
REQ-014 dma_rdata, dma_rvalid  output  DATA_W, 1  read return to the DMA.
REQ-015 resp_err  output  1  sticky flag: a response arrived with no read outstanding.

Function
REQ-016 Requester handshake: a requester SHALL hold req and its fields stable until gnt=1; gnt is combinational and is asserted for at most one requester per cycle.
REQ-017 Arbitration SHALL be round-robin.
- Only one requester active: that requester is granted.
- Both active: the requester not granted last time wins.
- Priority pointer after reset: cache first.
REQ-018 Read credits SHALL gate reads: a read is grantable only when outstanding < MAX_OUTSTANDING; writes are never credit-gated.
REQ-019 If the round-robin winner is credit-blocked, the other requester SHALL be granted when it is grantable.
REQ-020 Controller outputs SHALL be registered: a grant in cycle t drives In_valid=1, WR, Addr, Di and reader_sel in cycle t+1; In_valid=0 in any cycle following a no-grant cycle.
REQ-021 Each granted read SHALL push its owner (0 = DMA, 1 = CPU) into an in-order tag FIFO of depth 16; writes push nothing.
REQ-022 Response strobe = bram_Out_valid | bram_dma_ack; on a strobe, the FIFO head SHALL be popped and bram_Do routed by that head.
REQ-023 Routed response timing: at the next edge, the owner's rdata = bram_Do and the owner's rvalid is pulsed for exactly one cycle.
REQ-024 Outstanding counter: +1 per granted read, -1 per strobe; a simultaneous grant and strobe SHALL leave it unchanged, including at MAX_OUTSTANDING.
REQ-025 Strobe with the FIFO empty SHALL be dropped (no rvalid) and SHALL set resp_err until reset.
REQ-026 Responses SHALL return in issue order regardless of requester; no response reordering.
REQ-027 rdata registers SHALL hold their last value when rvalid=0.

Reset
REQ-028 On rst=1 at a clock edge, the following SHALL clear to 0: In_valid, WR, Addr, Di, reader_sel, cache_rvalid, dma_rvalid, cache_rdata, dma_rdata, resp_err, outstanding counter, FIFO pointers.
REQ-029 During reset the round-robin pointer SHALL return to cache priority and gnt SHALL be 0.
REQ-030 Reset mid-operation: in-flight reads SHALL be discarded; the controller shares rst, so no late strobes are expected, and any that do arrive raise resp_err.

Structure
REQ-031 The shared package bram_pkg SHALL hold ADDR_W, DATA_W, MAX_OUTSTANDING, the controller latency (10) and the reader_sel encoding (SEL_DMA=0, SEL_CPU=1).
REQ-032 One sub-module SHALL be used: tag_fifo, a synchronous 1-bit-wide, 16-deep FIFO with push, pop, empty and full, supporting simultaneous push and pop.

Verification
REQ-033 Single cache read to addr 0x010 (pre-written 0xDEADBEEF) -> cache_gnt in the request cycle, In_valid/reader_sel=1 one cycle later, cache_rvalid with 0xDEADBEEF 11 cycles after In_valid; dma_rvalid stays 0.
REQ-034 Cache and DMA issue continuous reads together for 20 cycles -> grants alternate C, D, C, D...; each rdata matches its own address; order is preserved.
REQ-035 DMA issues 12 back-to-back reads -> 10 granted, gnt low for the next cycles until the first strobe, then the 11th is granted in that strobe cycle; outstanding never exceeds 10.
REQ-036 Writes interleaved with credit-blocked reads -> writes granted while reads stall, no FIFO push; a readback returns the written data.
REQ-037 Force a strobe with no reads pending -> resp_err=1 and no rvalid; then assert rst for 1 cycle with 5 reads in flight -> all outputs 0, resp_err cleared, fresh read completes normally.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared constants and encodings for the BRAM arbiter slice.
// Sized for the CPU-cache / DMA front end of the BRAM controller.
package bram_pkg;

    localparam int ADDR_W          = 13;
    localparam int DATA_W          = 32;
    localparam int MAX_OUTSTANDING = 10;
    localparam int CTRL_LATENCY    = 10;
    localparam int TAG_DEPTH       = 16;

    typedef enum logic {
        SEL_DMA = 1'b0,
        SEL_CPU = 1'b1
    } sel_e;

endpackage

// File: rtl/bram_arbiter_tag_fifo.sv
// In-order owner tag FIFO for reads in flight to the controller.
// DEPTH must be a power of two; push and pop may coincide when full.
module tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic empty_o,
    output logic full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign dout_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers and occupancy.
    always_comb begin
        wptr_d = wptr_q + PW'(do_push);
        rptr_d = rptr_q + PW'(do_pop);
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Tag storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin, credit-gated arbiter between CPU cache and DMA in
// front of a fixed-latency BRAM controller, with in-order read return.
module bram_arbiter #(
    parameter int ADDR_W          = bram_pkg::ADDR_W,
    parameter int DATA_W          = bram_pkg::DATA_W,
    parameter int MAX_OUTSTANDING = bram_pkg::MAX_OUTSTANDING
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_req,
    input  logic              cache_wr,
    input  logic [ADDR_W-1:0] cache_addr,
    input  logic [DATA_W-1:0] cache_wdata,
    output logic              cache_gnt,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              WR,
    output logic              In_valid,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Di,
    output logic              reader_sel,
    input  logic [DATA_W-1:0] bram_Do,
    input  logic              bram_Out_valid,
    input  logic              bram_dma_ack,
    output logic [DATA_W-1:0] cache_rdata,
    output logic              cache_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              resp_err
);

    import bram_pkg::*;

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic              pri_cpu_q, pri_cpu_d;
    logic [OW-1:0]     out_q, out_d;
    logic              in_valid_q, wr_q, sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] di_q;
    logic              crv_q, drv_q, err_q;
    logic [DATA_W-1:0] crd_q, drd_q;

    logic strobe, pop, rd_ok;
    logic fifo_empty, fifo_full, head;
    logic c_ok, d_ok, c_gnt, d_gnt, g_any, g_wr, push;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    assign strobe = bram_Out_valid | bram_dma_ack;
    assign pop    = strobe && !fifo_empty;

    // A strobe in this cycle frees a credit and a FIFO slot immediately.
    assign rd_ok = ((out_q < OW'(MAX_OUTSTANDING)) || pop)
                && (!fifo_full || pop);
    assign c_ok  = cache_req && (cache_wr || rd_ok);
    assign d_ok  = dma_req && (dma_wr || rd_ok);

    // Round-robin pick; a blocked winner yields to the other side.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (c_ok && d_ok) begin
                c_gnt = pri_cpu_q;
                d_gnt = !pri_cpu_q;
            end else begin
                c_gnt = c_ok;
                d_gnt = d_ok;
            end
        end
    end

    assign g_any   = c_gnt | d_gnt;
    assign g_wr    = c_gnt ? cache_wr    : dma_wr;
    assign g_addr  = c_gnt ? cache_addr  : dma_addr;
    assign g_wdata = c_gnt ? cache_wdata : dma_wdata;
    assign push    = g_any && !g_wr;

    // Priority pointer and credit count next state.
    always_comb begin
        pri_cpu_d = pri_cpu_q;
        if (c_gnt) begin
            pri_cpu_d = 1'b0;
        end else if (d_gnt) begin
            pri_cpu_d = 1'b1;
        end
        out_d = out_q + OW'(push) - OW'(pop);
    end

    tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tags (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .din_i  (c_gnt),
        .pop_i  (pop),
        .dout_o (head),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    // Arbiter state, registered controller request and read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_cpu_q  <= 1'b1;
            out_q      <= '0;
            in_valid_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            di_q       <= '0;
            sel_q      <= 1'b0;
            crv_q      <= 1'b0;
            drv_q      <= 1'b0;
            crd_q      <= '0;
            drd_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            pri_cpu_q  <= pri_cpu_d;
            out_q      <= out_d;
            in_valid_q <= g_any;
            if (g_any) begin
                wr_q   <= g_wr;
                addr_q <= g_addr;
                di_q   <= g_wdata;
                sel_q  <= c_gnt ? SEL_CPU : SEL_DMA;
            end
            crv_q <= pop && (head == SEL_CPU);
            drv_q <= pop && (head == SEL_DMA);
            if (pop && (head == SEL_CPU)) begin
                crd_q <= bram_Do;
            end
            if (pop && (head == SEL_DMA)) begin
                drd_q <= bram_Do;
            end
            err_q <= err_q | (strobe && fifo_empty);
        end
    end

    assign cache_gnt    = c_gnt;
    assign dma_gnt      = d_gnt;
    assign In_valid     = in_valid_q;
    assign WR           = wr_q;
    assign Addr         = addr_q;
    assign Di           = di_q;
    assign reader_sel   = sel_q;
    assign cache_rvalid = crv_q;
    assign cache_rdata  = crd_q;
    assign dma_rvalid   = drv_q;
    assign dma_rdata    = drd_q;
    assign resp_err     = err_q;

endmodule
